// File: rtl/bram_port_arbiter_pkg.sv
// Shared types for the BRAM port arbiter: FSM states and return-pipeline entries.
package bram_arb_pkg;

    localparam int N_REQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } arb_state_t;

    typedef struct packed {
        logic                     valid;
        logic [$clog2(N_REQ)-1:0] owner;
    } rd_entry_t;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester and BRAM-side signals of the arbiter; slave = arbiter, master = requesters + BRAM.
interface bram_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                  r0_req;
    logic                  r0_we;
    logic                  r0_lock;
    logic [ADDR_W-1:0]     r0_addr;
    logic [DATA_W-1:0]     r0_wdata;
    logic [DATA_W/8-1:0]   r0_wstrb;
    logic                  r0_gnt;
    logic                  r0_rvalid;
    logic [DATA_W-1:0]     r0_rdata;

    logic                  r1_req;
    logic                  r1_we;
    logic                  r1_lock;
    logic [ADDR_W-1:0]     r1_addr;
    logic [DATA_W-1:0]     r1_wdata;
    logic [DATA_W/8-1:0]   r1_wstrb;
    logic                  r1_gnt;
    logic                  r1_rvalid;
    logic [DATA_W-1:0]     r1_rdata;

    logic                  bram_en;
    logic [DATA_W/8-1:0]   bram_we;
    logic [ADDR_W-1:0]     bram_addr;
    logic [DATA_W-1:0]     bram_wdata;
    logic [DATA_W-1:0]     bram_rdata;

    modport slave (
        input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata, r0_wstrb,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_wstrb,
        output r1_gnt, r1_rvalid, r1_rdata,
        output bram_en, bram_we, bram_addr, bram_wdata,
        input  bram_rdata
    );

    modport master (
        output r0_req, r0_we, r0_lock, r0_addr, r0_wdata, r0_wstrb,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_wstrb,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  bram_en, bram_we, bram_addr, bram_wdata,
        output bram_rdata
    );

endinterface

// File: rtl/bram_port_arbiter_rd_return_pipe.sv
// Read-return shift register: carries {valid, owner} alongside the BRAM read latency.
module bram_rd_return_pipe
    import bram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  rd_entry_t i_entry,
    output rd_entry_t o_entry
);

    rd_entry_t r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_entry;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_entry = r_stage[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Single-port BRAM arbiter for two requesters with lock ownership and read-data steering.
// Define BRAM_ARB_RR_EN for round-robin tie-break in IDLE; default is fixed priority to r0.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    bram_port_arbiter_if.slave bus
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic                w_tie_r0;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_grant;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [STRB_W-1:0]   w_wstrb;
    logic [ADDR_W-1:0]   r_addr_hold;
    logic [DATA_W-1:0]   r_wdata_hold;
    rd_entry_t           w_ret_in;
    rd_entry_t           w_ret_out;

`ifdef BRAM_ARB_RR_EN
    logic r_last;

    // Resets to 1 so requester 0 takes the first tie.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_gnt1;
        end
    end

    assign w_tie_r0 = r_last;
`else
    assign w_tie_r0 = 1'b1;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                w_gnt0 = bus.r0_req & (~bus.r1_req | w_tie_r0);
                w_gnt1 = bus.r1_req & ~w_gnt0;
                if (w_gnt0 && bus.r0_lock) begin
                    w_state_nxt = OWN0;
                end else if (w_gnt1 && bus.r1_lock) begin
                    w_state_nxt = OWN1;
                end
            end
            // Owner keeps the port until its lock drops, granted or not.
            OWN0: begin
                w_gnt0 = bus.r0_req;
                if (!bus.r0_lock) begin
                    w_state_nxt = IDLE;
                end
            end
            OWN1: begin
                w_gnt1 = bus.r1_req;
                if (!bus.r1_lock) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!ARESETN) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    assign w_grant = w_gnt0 | w_gnt1;
    assign w_we    = w_gnt1 ? bus.r1_we    : bus.r0_we;
    assign w_addr  = w_gnt1 ? bus.r1_addr  : bus.r0_addr;
    assign w_wdata = w_gnt1 ? bus.r1_wdata : bus.r0_wdata;
    assign w_wstrb = w_gnt1 ? bus.r1_wstrb : bus.r0_wstrb;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
        end else if (w_grant) begin
            r_addr_hold  <= w_addr;
            r_wdata_hold <= w_wdata;
        end
    end

    assign bus.bram_en    = w_grant;
    assign bus.bram_we    = (w_grant && w_we) ? w_wstrb : '0;
    assign bus.bram_addr  = w_grant ? w_addr  : r_addr_hold;
    assign bus.bram_wdata = w_grant ? w_wdata : r_wdata_hold;

    assign bus.r0_gnt = w_gnt0;
    assign bus.r1_gnt = w_gnt1;

    always_comb begin
        w_ret_in       = '0;
        w_ret_in.valid = w_grant & ~w_we;
        w_ret_in.owner = w_gnt1;
    end

    bram_rd_return_pipe #(
        .DEPTH (RD_LAT)
    ) u_ret_pipe (
        .i_clk   (ACLK),
        .i_rst_n (ARESETN),
        .i_entry (w_ret_in),
        .o_entry (w_ret_out)
    );

    assign bus.r0_rvalid = w_ret_out.valid & (w_ret_out.owner == 1'b0);
    assign bus.r1_rvalid = w_ret_out.valid & (w_ret_out.owner == 1'b1);
    assign bus.r0_rdata  = ARESETN ? bus.bram_rdata : '0;
    assign bus.r1_rdata  = ARESETN ? bus.bram_rdata : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed + random bench for bram_port_arbiter against a cycle-level behavioural model.
module tb_bram_port_arbiter;

    parameter int RD_LAT = 1;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
`ifdef BRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic ACLK = 1'b0;
    logic ARESETN;
    always #5 ACLK = ~ACLK;

    bram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bram_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus)
    );

    // BRAM primitive model: read-first, RD_LAT-cycle read latency
    logic [31:0] bram_mem [0:1023] = '{default: '0};
    logic [31:0] bram_pipe [RD_LAT];
    always @(posedge ACLK) begin
        if (bus.bram_en) begin
            bram_pipe[0] <= bram_mem[bus.bram_addr];
            for (int b = 0; b < 4; b++)
                if (bus.bram_we[b]) bram_mem[bus.bram_addr][8*b +: 8] <= bus.bram_wdata[8*b +: 8];
        end
        for (int i = 1; i < RD_LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign bus.bram_rdata = bram_pipe[RD_LAT-1];

    // Reference model state
    typedef struct {
        int          due;
        bit          owner;
        logic [31:0] data;
    } ret_t;

    logic [31:0] ref_mem [0:1023] = '{default: '0};
    ret_t        pend [$];
    int          own;        // 0 none, 1 = r0 owns, 2 = r1 owns
    bit          last;       // last winner, used only for round-robin ties
    int          cyc;
    int          checks;
    int          failures;
    int          rv0_cyc, rv1_cyc;
    logic [31:0] rv0_dat, rv1_dat;
    bit          obs_g0, obs_g1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_r0(input bit req, input bit we, input bit lock, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
        bus.r0_req = req; bus.r0_we = we; bus.r0_lock = lock;
        bus.r0_addr = addr; bus.r0_wdata = wdata; bus.r0_wstrb = wstrb;
    endtask

    task automatic set_r1(input bit req, input bit we, input bit lock, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
        bus.r1_req = req; bus.r1_we = we; bus.r1_lock = lock;
        bus.r1_addr = addr; bus.r1_wdata = wdata; bus.r1_wstrb = wstrb;
    endtask

    task automatic idle_reqs();
        set_r0(0, 0, 0, '0, '0, '0);
        set_r1(0, 0, 0, '0, '0, '0);
    endtask

    task automatic apply_reset();
        ARESETN = 1'b0;
        pend.delete();
        own  = 0;
        last = 1'b1;
    endtask

    // One clock cycle: check combinational outputs and returns at negedge, then advance model.
    task automatic cycle();
        bit          g0, g1, w, lk, ev0, ev1;
        int          own_start;
        logic [9:0]  a;
        logic [31:0] d, ed;
        logic [3:0]  s;
        bit          we;
        @(negedge ACLK);
        g0 = 0; g1 = 0;
        if (ARESETN) begin
            if (own == 1) g0 = bus.r0_req;
            else if (own == 2) g1 = bus.r1_req;
            else if (bus.r0_req && bus.r1_req) begin
                if (RR && !last) g1 = 1; else g0 = 1;
            end else begin
                g0 = bus.r0_req; g1 = bus.r1_req;
            end
        end
        obs_g0 = bus.r0_gnt; obs_g1 = bus.r1_gnt;
        check("gnt0", bus.r0_gnt, g0);
        check("gnt1", bus.r1_gnt, g1);
        check("bram_en", bus.bram_en, g0 | g1);
        w  = g1;
        we = w ? bus.r1_we    : bus.r0_we;
        a  = w ? bus.r1_addr  : bus.r0_addr;
        d  = w ? bus.r1_wdata : bus.r0_wdata;
        s  = w ? bus.r1_wstrb : bus.r0_wstrb;
        lk = w ? bus.r1_lock  : bus.r0_lock;
        if (g0 || g1) begin
            check("bram_addr", bus.bram_addr, a);
            check("bram_wdata", bus.bram_wdata, d);
            check("bram_we", bus.bram_we, we ? s : 4'b0);
        end else begin
            check("bram_we_idle", bus.bram_we, 4'b0);
        end
        if (!ARESETN) begin
            check("rst_addr", bus.bram_addr, 0);
            check("rst_wdata", bus.bram_wdata, 0);
            check("rst_rdata0", bus.r0_rdata, 0);
            check("rst_rdata1", bus.r1_rdata, 0);
        end
        ev0 = 0; ev1 = 0; ed = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            if (pend[0].owner) ev1 = 1; else ev0 = 1;
            ed = pend[0].data;
            void'(pend.pop_front());
        end
        check("rvalid0", bus.r0_rvalid, ev0);
        check("rvalid1", bus.r1_rvalid, ev1);
        if (ev0) check("rdata0", bus.r0_rdata, ed);
        if (ev1) check("rdata1", bus.r1_rdata, ed);
        if (bus.r0_rvalid === 1'b1) begin rv0_cyc = cyc; rv0_dat = bus.r0_rdata; end
        if (bus.r1_rvalid === 1'b1) begin rv1_cyc = cyc; rv1_dat = bus.r1_rdata; end
        own_start = own;
        if (g0 || g1) begin
            if (we) begin
                for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            end else begin
                pend.push_back('{due: cyc + RD_LAT, owner: w, data: ref_mem[a]});
            end
            last = w;
            if (own_start == 0 && lk) own = w ? 2 : 1;
        end
        if (own_start == 1 && !bus.r0_lock) own = 0;
        if (own_start == 2 && !bus.r1_lock) own = 0;
        @(posedge ACLK);
        #1;
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        idle_reqs();
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int          c0, saved;
        logic [3:0]  tie_g1;
        logic [31:0] d10, d20;

        checks = 0; failures = 0; cyc = 0;
        rv0_cyc = -1; rv1_cyc = -1; rv0_dat = '0; rv1_dat = '0;
        idle_reqs();
        apply_reset();
        // Requests during reset must be ignored and all outputs held at 0
        set_r0(1, 0, 1, 10'h3, 32'h1234, 4'hF);
        set_r1(1, 1, 1, 10'h5, 32'h5678, 4'hF);
        cycle(); cycle();
        ARESETN = 1'b1;

        // Single read after a write
        idle_reqs();
        set_r0(1, 1, 0, 10'h004, 32'h0000_0002, 4'hF);
        cycle();
        set_r0(1, 0, 0, 10'h004, 32'h0, 4'h0);
        c0 = cyc;
        cycle();
        check("single_gnt", obs_g0, 1);
        idle_cycles(RD_LAT);
        check("single_rv_cyc", rv0_cyc, c0 + RD_LAT);
        check("single_rdata", rv0_dat, 32'h0000_0002);
        check("single_no_rv1", rv1_cyc >= c0, 0);

        // Unlocked tie for 4 cycles, preceded by an r1 access
        set_r1(1, 1, 0, 10'h008, 32'hCAFE_0001, 4'hF);
        cycle();
        set_r0(1, 0, 0, 10'h004, 32'h0, 4'h0);
        set_r1(1, 0, 0, 10'h008, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            tie_g1[i] = obs_g1;
        end
        check("tie_pattern", tie_g1, RR ? 4'b1010 : 4'b0000);
        idle_cycles(RD_LAT + 1);

        // Lock burst by r1 while r0 keeps requesting
        for (int i = 0; i < 8; i++) begin
            set_r1(1, 1, i != 7, 10'h100 + 10'(i), $urandom, 4'hF);
            cycle();
            check("burst_gnt1", obs_g1, 1);
            check("burst_no_gnt0", obs_g0, 0);
            if (i == 0) set_r0(1, 0, 0, 10'h100, 32'h0, 4'h0);
        end
        set_r1(0, 0, 0, '0, '0, '0);
        cycle();
        check("burst_then_r0", obs_g0, 1);
        idle_cycles(RD_LAT + 1);

        // Byte strobes
        set_r0(1, 1, 0, 10'h030, 32'h1111_1111, 4'hF);
        cycle();
        set_r0(1, 1, 0, 10'h030, 32'hAABB_CCDD, 4'b0101);
        cycle();
        set_r0(1, 0, 0, 10'h030, 32'h0, 4'h0);
        c0 = cyc;
        cycle();
        idle_cycles(RD_LAT);
        check("strobe_rv_cyc", rv0_cyc, c0 + RD_LAT);
        check("strobe_rdata", rv0_dat, 32'h11BB_11DD);

        // Interleaved reads return in issue order to their own requester
        d10 = $urandom; d20 = $urandom;
        set_r0(1, 1, 0, 10'h010, d10, 4'hF);
        cycle();
        idle_reqs();
        set_r1(1, 1, 0, 10'h020, d20, 4'hF);
        cycle();
        set_r1(0, 0, 0, '0, '0, '0);
        set_r0(1, 0, 0, 10'h010, 32'h0, 4'h0);
        c0 = cyc;
        cycle();
        set_r0(0, 0, 0, '0, '0, '0);
        set_r1(1, 0, 0, 10'h020, 32'h0, 4'h0);
        cycle();
        idle_cycles(RD_LAT);
        check("ilv_rv0_cyc", rv0_cyc, c0 + RD_LAT);
        check("ilv_rv1_cyc", rv1_cyc, c0 + 1 + RD_LAT);
        check("ilv_rdata0", rv0_dat, d10);
        check("ilv_rdata1", rv1_dat, d20);

        // Reset while r1 owns the port with a read in flight
        set_r1(1, 0, 1, 10'h004, 32'h0, 4'h0);
        cycle();
        check("rst_r1_gnt", obs_g1, 1);
        saved = rv1_cyc;
        apply_reset();
        cycle(); cycle();
        set_r1(0, 0, 0, '0, '0, '0);
        ARESETN = 1'b1;
        set_r0(1, 0, 0, 10'h004, 32'h0, 4'h0);
        cycle();
        check("post_rst_r0_gnt", obs_g0, 1);
        idle_cycles(RD_LAT + 1);
        check("rst_drop_rv1", rv1_cyc, saved);

        // Random traffic over a small address window
        for (int i = 0; i < 400; i++) begin
            set_r0($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                   10'h200 + 10'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            set_r1($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                   10'h200 + 10'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            cycle();
        end
        idle_cycles(RD_LAT + 2);
        check("drain_empty", pend.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
